// File: rtl/gpr_bank.sv
// Bank of DEPTH general-purpose bus registers with load/inc/dec/clear and zero/carry flags.
// Define GPR_BANK_TRISTATE_EN to float data_out when oa=0; otherwise it idles at all-zeros.
module gpr_bank #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              wa,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [1:0]        op,
  input  logic              oa,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  data_out,
  output logic              zero,
  output logic              carry
);

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] new_val;
  logic             new_carry;
  logic             w_hit;
  logic [WIDTH-1:0] rd_val;

  // Address decode by matching every implemented index, so out-of-range addresses simply miss.
  always_comb begin
    cur_val = '0;
    w_hit   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (waddr == ADDR_W'(i)) begin
        cur_val = regs[i];
        w_hit   = 1'b1;
      end
    end
  end

  always_comb begin
    new_val   = '0;
    new_carry = 1'b0;
    case (op_e'(op))
      OP_LOAD: new_val = data_in;
      OP_INC: begin
        new_val   = cur_val + WIDTH'(1);
        new_carry = &cur_val;
      end
      OP_DEC: begin
        new_val   = cur_val - WIDTH'(1);
        new_carry = (cur_val == '0);
      end
      default: new_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      zero  <= 1'b0;
      carry <= 1'b0;
    end else if (wa && w_hit) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr == ADDR_W'(i)) begin
          regs[i] <= new_val;
        end
      end
      zero  <= (new_val == '0);
      carry <= new_carry;
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == ADDR_W'(i)) begin
        rd_val = regs[i];
      end
    end
  end

`ifdef GPR_BANK_TRISTATE_EN
  assign data_out = oa ? rd_val : {WIDTH{1'bz}};
`else
  assign data_out = oa ? rd_val : '0;
`endif

endmodule

// File: tb/tb_gpr_bank.sv
// Directed testbench for gpr_bank: a DEPTH=4 bank plus a DEPTH=3 bank for range behaviour.
module tb_gpr_bank;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [7:0] data_in;
  logic       wa;
  logic [1:0] waddr;
  logic [1:0] op;
  logic       oa;
  logic [1:0] raddr;
  wire  [7:0] data_out;
  wire        zero;
  wire        carry;
  wire  [7:0] data_out3;
  wire        zero3;
  wire        carry3;

  int checks = 0;
  int errors = 0;

`ifdef GPR_BANK_TRISTATE_EN
  localparam logic [7:0] IDLE = 8'hzz;
`else
  localparam logic [7:0] IDLE = 8'h00;
`endif

  always #5 clk = ~clk;

  gpr_bank #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) u_dut (
    .clk(clk), .clr_n(clr_n), .data_in(data_in), .wa(wa), .waddr(waddr), .op(op),
    .oa(oa), .raddr(raddr), .data_out(data_out), .zero(zero), .carry(carry)
  );

  gpr_bank #(.WIDTH(8), .DEPTH(3), .ADDR_W(2)) u_dut3 (
    .clk(clk), .clr_n(clr_n), .data_in(data_in), .wa(wa), .waddr(waddr), .op(op),
    .oa(oa), .raddr(raddr), .data_out(data_out3), .zero(zero3), .carry(carry3)
  );

  task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_flags(input string tag, input logic z_obs, input logic z_exp,
                             input logic c_obs, input logic c_exp);
    check_output({tag, "_zero"}, {7'b0, z_obs}, {7'b0, z_exp});
    check_output({tag, "_carry"}, {7'b0, c_obs}, {7'b0, c_exp});
  endtask

  // One write edge; returns 1 time unit after the capturing edge with wa released.
  task automatic apply_stimulus(input logic [1:0] w_op, input logic [1:0] w_addr, input logic [7:0] w_data);
    wa      = 1'b1;
    op      = w_op;
    waddr   = w_addr;
    data_in = w_data;
    @(posedge clk);
    #1;
    wa = 1'b0;
  endtask

  task automatic read_at(input logic [1:0] addr);
    raddr = addr;
    #1;
  endtask

  initial begin
    clr_n = 1'b0; wa = 1'b0; waddr = 2'd0; op = 2'b00; data_in = 8'h00; oa = 1'b1; raddr = 2'd0;
    #2;
    check_output("reset_data", data_out, 8'h00);
    check_flags("reset", zero, 1'b0, carry, 1'b0);
    #5 clr_n = 1'b1;

    // Load and read back, other registers untouched
    apply_stimulus(2'b00, 2'd1, 8'h55);
    read_at(2'd1); check_output("load_r1", data_out, 8'h55);
    check_flags("load", zero, 1'b0, carry, 1'b0);
    read_at(2'd0); check_output("load_r0", data_out, 8'h00);
    read_at(2'd2); check_output("load_r2", data_out, 8'h00);
    read_at(2'd3); check_output("load_r3", data_out, 8'h00);

    // Increment wrap and recovery
    apply_stimulus(2'b00, 2'd3, 8'hFF);
    apply_stimulus(2'b01, 2'd3, 8'h00);
    read_at(2'd3); check_output("inc_wrap", data_out, 8'h00);
    check_flags("inc_wrap", zero, 1'b1, carry, 1'b1);
    apply_stimulus(2'b01, 2'd3, 8'h00);
    read_at(2'd3); check_output("inc_again", data_out, 8'h01);
    check_flags("inc_again", zero, 1'b0, carry, 1'b0);

    // Decrement borrow then clear
    apply_stimulus(2'b10, 2'd0, 8'h00);
    read_at(2'd0); check_output("dec_borrow", data_out, 8'hFF);
    check_flags("dec_borrow", zero, 1'b0, carry, 1'b1);
    apply_stimulus(2'b11, 2'd0, 8'hAA);
    read_at(2'd0); check_output("clear", data_out, 8'h00);
    check_flags("clear", zero, 1'b1, carry, 1'b0);
    read_at(2'd1); check_output("r1_undisturbed", data_out, 8'h55);

    // Same-cycle read and write: old value until the edge
    apply_stimulus(2'b00, 2'd2, 8'h10);
    raddr = 2'd2;
    wa = 1'b1; op = 2'b00; waddr = 2'd2; data_in = 8'h20;
    #1 check_output("rw_before", data_out, 8'h10);
    @(posedge clk);
    #1 check_output("rw_after", data_out, 8'h20);
    wa = 1'b0; op = 2'b11; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_output("hold_data", data_out, 8'h20);
    check_flags("hold", zero, 1'b0, carry, 1'b0);

    // Idle bus value
    oa = 1'b0;
    #1 check_output("idle", data_out, IDLE);
    oa = 1'b1;

    // Asynchronous reset mid-cycle with flags set
    apply_stimulus(2'b00, 2'd2, 8'h5A);
    apply_stimulus(2'b00, 2'd3, 8'hFF);
    apply_stimulus(2'b01, 2'd3, 8'h00);
    read_at(2'd2); check_output("pre_reset", data_out, 8'h5A);
    check_flags("pre_reset", zero, 1'b1, carry, 1'b1);
    #1 clr_n = 1'b0;
    #1 check_output("async_reset", data_out, 8'h00);
    check_flags("async_reset", zero, 1'b0, carry, 1'b0);
    #2 clr_n = 1'b1;

    // Out-of-range behaviour on the DEPTH=3 bank
    apply_stimulus(2'b00, 2'd2, 8'hFF);
    apply_stimulus(2'b01, 2'd2, 8'h00);
    check_flags("d3_wrap", zero3, 1'b1, carry3, 1'b1);
    apply_stimulus(2'b01, 2'd3, 8'h00);
    check_flags("d3_oor_hold", zero3, 1'b1, carry3, 1'b1);
    check_flags("d4_r3_inc", zero, 1'b0, carry, 1'b0);
    read_at(2'd3);
    check_output("d3_oor_read", data_out3, 8'h00);
    check_output("d4_r3_read", data_out, 8'h01);
    read_at(2'd2);
    check_output("d3_r2", data_out3, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_bank.md
# gpr_bank

Parametrised bank of general-purpose bus registers for the 8-bit datapath. It generalises the single load/output register to DEPTH addressable registers of WIDTH bits each. Every register supports in-place increment, decrement and clear, and the bank maintains zero and carry flags for the sequencer. It sits on the shared data bus: writes load from the bus and the read port drives the bus when output-asserted.

## Interface
Parameters:
- WIDTH, 8, bits per register
- DEPTH, 4, number of registers; must satisfy 1 <= DEPTH <= 2**ADDR_W
- ADDR_W, 2, address width of waddr/raddr

Ports:
- clk  in  1  clock; all state changes on the rising edge
- clr_n  in  1  asynchronous, active-low reset
- data_in  in  WIDTH  bus value for load
- wa  in  1  write assert; performs op on register waddr at the next rising edge
- waddr  in  ADDR_W  target register of the write/op
- op  in  2  00 load data_in, 01 increment, 10 decrement, 11 clear
- oa  in  1  output assert; drives data_out from register raddr
- raddr  in  ADDR_W  register driven onto data_out
- data_out  out  WIDTH  bus output (see Configuration for the non-asserted value)
- zero  out  1  registered: result of last executed write was 0
- carry  out  1  registered: wrap-around on last inc/dec

## Operation
- Reset (clr_n=0, asynchronous, any time including mid-operation): all registers = 0, zero = 0, carry = 0. Reset dominates wa. data_out follows the reset register contents immediately if oa=1.
- Write cycle (wa=1, waddr < DEPTH), at the rising edge:
  - op=00: reg <= data_in; carry <= 0
  - op=01: reg <= reg+1 mod 2**WIDTH; carry <= 1 iff old reg == all-ones
  - op=10: reg <= reg-1 mod 2**WIDTH; carry <= 1 iff old reg == 0 (borrow)
  - op=11: reg <= 0; carry <= 0
  - zero <= (new reg value == 0)
- wa=0: registers and flags hold; op and waddr are don't-care.
- Out-of-range waddr (>= DEPTH) with wa=1: registers unchanged, and zero and carry hold.
- Read: data_out = oa ? reg[raddr] : idle value. The read port is combinational from the stored value. Out-of-range raddr returns 0.
- Same register written and read in one cycle: data_out shows the old value until the edge, then the new value (no write-through).
- Only one write per cycle. Non-addressed registers are never disturbed.

## Timing
- Write/op latency: 1 cycle. Result is visible on data_out (and on the flags) immediately after the capturing rising edge.
- Read latency: 0 cycles (combinational from raddr/oa to data_out).
- Flags change only on an executed in-range write edge or on reset.
- Inputs wa, waddr, op and data_in must be stable around the rising edge. raddr and oa may change at any time.

## Configuration
- GPR_BANK_TRISTATE_EN defined: when oa=0, data_out is high-impedance (all bits 'z'), so the bank can share a tri-state bus with other drivers.
- GPR_BANK_TRISTATE_EN undefined: when oa=0, data_out is driven all-zeros, for a mux/OR-based bus. All other behaviour is identical.

## Test plan
Defaults WIDTH=8, DEPTH=4 unless stated.
- Reset: assert clr_n=0 mid-cycle with oa=1, raddr=2 after loading 0x5A -> data_out drops to 0x00 asynchronously; zero=0; carry=0.
- Load/read: wa=1, op=00, waddr=1, data_in=0x55, one edge -> with oa=1, raddr=1, data_out=0x55; zero=0; registers 0, 2, 3 remain 0x00.
- Increment wrap: load 0xFF into reg 3, then wa=1, op=01 -> reg 3 = 0x00, carry=1, zero=1. A second increment -> 0x01, carry=0, zero=0.
- Decrement borrow: reg 0 = 0x00, wa=1, op=10 -> reg 0 = 0xFF, carry=1, zero=0. Then op=11 -> reg 0 = 0x00, carry=0, zero=1.
- Same-cycle read/write: oa=1, raddr=waddr=2, reg 2 = 0x10, load 0x20 -> data_out=0x10 before the edge, 0x20 after. Then wa=0 for 3 cycles -> value and flags hold.
- Bus idle and range: oa=0 -> data_out = 'z' with GPR_BANK_TRISTATE_EN, 0x00 without. With DEPTH=3, a write to waddr=3 is ignored (flags hold), and raddr=3 with oa=1 -> data_out=0x00.
